dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Direct-mapped, write-back L1 data cache that answers the datapath's data-side requests on datapath_cache_if: dmemREN/dmemWEN/dmemaddr/dmemstore in; dhit/dmemload out.
- Fills and evicts through a single-word memory port with a dwait handshake.
- On halt, writes back every dirty block, then asserts flushed.
- Sits between the pipeline's MEM stage and the memory controller/arbiter.

Parameters:
- SETS, 8, number of frames (power of 2).
- BLKW, 2, words per block (fixed 2 in this revision).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- halt  in  1  datapath halt; begins flush.
- dmemREN  in  1  datapath read request.
- dmemWEN  in  1  datapath write request (never asserted together with dmemREN).
- dmemaddr  in  32  byte address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- dhit  out  1  request serviced this cycle.
- dmemload  out  32  read data, valid when dhit and dmemREN.
- flushed  out  1  flush complete; held until reset.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; a word transfers at a clock edge where dwait=0 and dREN or dWEN is high.
- dload  in  32  memory read data, valid when dwait=0.

Behaviour:
- Address split: tag=[31:3+log2(SETS)], idx=[2+log2(SETS):3], blkoff=[2], byteoff=[1:0].
- Frame contents: valid, dirty, tag, word[0:1].
- Reset (async, any state): all valid/dirty cleared, state IDLE, word counter 0, flushed=0. dhit, dREN, dWEN, daddr, dstore and dmemload all 0.
- Outputs are combinational from state and frame; no output registers.
- IDLE:
  - hit = (dmemREN|dmemWEN) & valid[idx] & tag match; dhit=hit in the same cycle (0-cycle hit latency).
  - Read hit: dmemload=word[idx][blkoff]. dmemload=0 whenever no read hit.
  - Write hit: word written and dirty set at the next edge.
  - Miss, victim valid&dirty: go to WB0.
  - Miss, otherwise: go to LD0.
  - halt=1: go to FLUSH, even if a request is present. halt has priority; no dhit is given.
- WB0/WB1: dWEN=1, daddr={victim tag,idx,blkoff=0/1,2'b00}, dstore=victim word 0/1. Advance on dwait=0.
- LD0/LD1: dREN=1, daddr={req tag,idx,0/1,2'b00}. On dwait=0, dload is written into word 0/1.
  - Leaving LD1: set valid, tag=req tag, dirty=0, return to IDLE.
  - The request is re-evaluated in IDLE the next cycle and hits. Miss penalty = memory cycles + 1.
- dhit is 0 in every non-IDLE state. The datapath holds its request stable until dhit.
- FLUSH:
  - A set counter walks 0..SETS-1.
  - Set is valid&dirty: FW0, then FW1 (same write handshake as WB, using the frame's tag), then clear dirty and increment.
  - Otherwise: increment the next cycle.
  - After set SETS-1: go to DONE.
- DONE: flushed=1. No further memory traffic or dhit until RST.
- dwait held high indefinitely: the FSM stalls with dREN/dWEN, daddr and dstore stable.
- Wrap-around: the set counter is log2(SETS)+1 bits, so terminal detection never aliases to 0.
- Reset mid-fill: the partially written frame stays invalid because valid is cleared.

Decomposition:
- cpu_types_pkg gains:
  - dcachef_t: packed tag/idx/blkoff/bytoff address view.
  - dcache_frame_t: valid, dirty, tag, word_t [1:0].
  - dcache_state_t enum: IDLE, WB0, WB1, LD0, LD1, FLUSH, FW0, FW1, DONE.
- One sub-module, dcache_frame_array. It holds the SETS frames with async-high reset clear, combinational read at idx, and synchronous per-word write, valid/dirty set and clear. It is owned by the FSM in dcache_responder.

Test Plan:
- Cold read 0x00000104 (SETS=8):
  - Expected memory reads: 0x100 then 0x104, each with dwait low one cycle.
  - Then dhit=1 with dmemload = the word supplied for 0x104.
  - Total 3 cycles after a 1-cycle-dwait memory.
- Read hit:
  - Second read of 0x100 after the fill gives dhit in the same cycle.
  - dREN never rises.
- Write hit then conflict:
  - Write 0xDEADBEEF to 0x100.
  - Read 0x140 (same idx=0): WB0/WB1 write 0x100=0xDEADBEEF and 0x104=old data.
  - Then fills from 0x140/0x144, then dhit.
- Halt flush with dirty sets 0 and 5 only:
  - Exactly 4 memory writes, to 0x100/0x104 and set 5's addresses.
  - flushed=1 on the cycle after set 7 is checked; it stays high.
- dwait stall:
  - Hold dwait=1 for 10 cycles during LD0; daddr stays stable and dhit stays 0.
  - Release; the fill completes correctly.
- Assert RST during LD1:
  - All outputs go to 0 immediately.
  - After release, a read to the same address misses again and does a full 2-word fill.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data-cache address view, frame layout and controller states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned DC_SETS = 8;
   localparam int unsigned DC_IDXW = $clog2(DC_SETS);
   localparam int unsigned DC_TAGW = 29 - DC_IDXW;

   typedef struct packed {
      logic [DC_TAGW-1:0] tag;
      logic [DC_IDXW-1:0] idx;
      logic               blkoff;
      logic [1:0]         bytoff;
   } dcachef_t;

   // Frame tag is kept zero-extended to 29 bits so any SETS >= 2 fits.
   typedef struct packed {
      logic         valid;
      logic         dirty;
      logic [28:0]  tag;
      word_t [1:0]  word;
   } dcache_frame_t;

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, LD0, LD1, FLUSH, FW0, FW1, DONE
   } dcache_state_t;

   function automatic word_t dc_addr(input logic [28:0] tag, input logic [28:0] idx,
                                     input logic blk, input int unsigned idxw);
      return (word_t'(tag) << (3 + idxw)) | (word_t'(idx) << 3) | (word_t'(blk) << 2);
   endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Frame storage for the direct-mapped data cache: combinational read and
// synchronous update at a single index, valid/dirty cleared by reset.
module dcache_frame_array
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = DC_SETS
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [$clog2(SETS)-1:0] idx,
   input  logic                    word_we,
   input  logic                    word_sel,
   input  word_t                   word_data,
   input  logic                    dirty_set,
   input  logic                    dirty_clr,
   input  logic                    fill_done,
   input  logic [28:0]             fill_tag,
   output dcache_frame_t           frame
);

   logic [SETS-1:0] valid;
   logic [SETS-1:0] dirty;
   logic [28:0]     tags  [SETS];
   word_t           words [SETS][2];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (dirty_set) begin
            dirty[idx] <= 1'b1;
         end else if (dirty_clr) begin
            dirty[idx] <= 1'b0;
         end
      end
   end

   // Data and tags need no reset: a frame is meaningless until valid is set.
   always_ff @(posedge CLK) begin
      if (word_we)   words[idx][word_sel] <= word_data;
      if (fill_done) tags[idx]            <= fill_tag;
   end

   assign frame = {valid[idx], dirty[idx], tags[idx], words[idx][1], words[idx][0]};

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back L1 data cache with 2-word blocks, single-word
// memory port with dwait handshake, and halt-triggered flush of dirty frames.
module dcache_responder
   import cpu_types_pkg::*;
#(
   parameter int unsigned SETS = DC_SETS,
   parameter int unsigned BLKW = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        halt,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);

   localparam int unsigned IDXW = $clog2(SETS);

   dcache_state_t   state, next;
   logic [IDXW:0]   setcnt;
   logic            cnt_inc;
   logic            last_set;
   logic [IDXW-1:0] req_idx, idx;
   logic [28:0]     req_tag;
   logic            blk;
   logic            hit;
   dcache_frame_t   frame;

   logic  word_we, word_sel, dirty_set, dirty_clr, fill_done;
   word_t word_data;

   assign req_idx  = dmemaddr[2+IDXW:3];
   assign req_tag  = 29'(dmemaddr >> (3 + IDXW));
   assign blk      = dmemaddr[2];
   assign idx      = (state inside {FLUSH, FW0, FW1}) ? setcnt[IDXW-1:0] : req_idx;
   assign last_set = (setcnt == (IDXW+1)'(SETS - 1));
   assign hit      = (dmemREN || dmemWEN) && frame.valid && (frame.tag == req_tag);

   dcache_frame_array #(.SETS(SETS)) u_frames (
      .CLK       (CLK),
      .RST       (RST),
      .idx       (idx),
      .word_we   (word_we),
      .word_sel  (word_sel),
      .word_data (word_data),
      .dirty_set (dirty_set),
      .dirty_clr (dirty_clr),
      .fill_done (fill_done),
      .fill_tag  (req_tag),
      .frame     (frame)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         setcnt <= '0;
      end else begin
         state <= next;
         if (cnt_inc) setcnt <= setcnt + (IDXW+1)'(1);
      end
   end

   always_comb begin
      next      = state;
      dhit      = 1'b0;
      dmemload  = '0;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      daddr     = '0;
      dstore    = '0;
      flushed   = 1'b0;
      word_we   = 1'b0;
      word_sel  = 1'b0;
      word_data = '0;
      dirty_set = 1'b0;
      dirty_clr = 1'b0;
      fill_done = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (halt) begin
               next = FLUSH;
            end else if (dmemREN || dmemWEN) begin
               if (hit) begin
                  dhit = 1'b1;
                  if (dmemREN) dmemload = frame.word[blk];
                  if (dmemWEN) begin
                     word_we   = 1'b1;
                     word_sel  = blk;
                     word_data = dmemstore;
                     dirty_set = 1'b1;
                  end
               end else if (frame.valid && frame.dirty) begin
                  next = WB0;
               end else begin
                  next = LD0;
               end
            end
         end
         WB0, WB1: begin
            dWEN   = 1'b1;
            daddr  = dc_addr(frame.tag, 29'(idx), state == WB1, IDXW);
            dstore = frame.word[state == WB1];
            if (!dwait) next = (state == WB0) ? WB1 : LD0;
         end
         LD0, LD1: begin
            dREN  = 1'b1;
            daddr = dc_addr(req_tag, 29'(idx), state == LD1, IDXW);
            if (!dwait) begin
               word_we   = 1'b1;
               word_sel  = (state == LD1);
               word_data = dload;
               if (state == LD0) begin
                  next = LD1;
               end else begin
                  fill_done = 1'b1;
                  next      = IDLE;
               end
            end
         end
         FLUSH: begin
            if (frame.valid && frame.dirty) begin
               next = FW0;
            end else begin
               cnt_inc = 1'b1;
               next    = last_set ? DONE : FLUSH;
            end
         end
         FW0, FW1: begin
            dWEN   = 1'b1;
            daddr  = dc_addr(frame.tag, 29'(idx), state == FW1, IDXW);
            dstore = frame.word[state == FW1];
            if (!dwait) begin
               if (state == FW0) begin
                  next = FW1;
               end else begin
                  dirty_clr = 1'b1;
                  cnt_inc   = 1'b1;
                  next      = last_set ? DONE : FLUSH;
               end
            end
         end
         DONE:    flushed = 1'b1;
         default: next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: memory model plus scoreboard queues of
// expected memory transfers and expected read data.
module tb_dcache_responder;
   import cpu_types_pkg::*;

   localparam int unsigned SETS = 8;

   logic        CLK = 1'b0;
   logic        RST, halt, dmemREN, dmemWEN, dhit, flushed, dREN, dWEN, dwait;
   logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

   always #5 CLK = ~CLK;

   dcache_responder #(.SETS(SETS), .BLKW(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .halt      (halt),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .dmemaddr  (dmemaddr),
      .dmemstore (dmemstore),
      .dhit      (dhit),
      .dmemload  (dmemload),
      .flushed   (flushed),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dwait     (dwait),
      .dload     (dload)
   );

   typedef struct {
      logic  we;
      word_t addr;
      word_t data;
   } memop_t;

   memop_t      mq[$];
   word_t       rq[$];
   word_t       mem [word_t];
   int unsigned vectors = 0;
   int unsigned errors  = 0;
   int unsigned stall_cycles = 0;
   int unsigned nwrites = 0;
   int unsigned lat;
   int unsigned w0;
   int unsigned cyc;

   function automatic word_t memrd(input word_t a);
      return mem.exists(a) ? mem[a] : ((a ^ 32'h5A5A0000) + 32'h11);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_fill(input word_t a);
      mq.push_back('{1'b0, a & 32'hFFFF_FFF8, 32'h0});
      mq.push_back('{1'b0, (a & 32'hFFFF_FFF8) | 32'h4, 32'h0});
   endtask

   task automatic expect_wr(input word_t a, input word_t d);
      mq.push_back('{1'b1, a, d});
   endtask

   // One clock: memory answers at the falling edge, transfer happens at the rising edge.
   task automatic step();
      memop_t op;
      @(negedge CLK);
      dwait = 1'b0;
      if ((dREN || dWEN) && stall_cycles != 0) begin
         dwait = 1'b1;
         stall_cycles--;
      end
      dload = memrd(daddr);
      if ((dREN || dWEN) && !dwait) begin
         check("memq_nonempty", {31'b0, mq.size() != 0}, 32'd1);
         if (mq.size() != 0) begin
            op = mq.pop_front();
            check("mem_we", {31'b0, dWEN}, {31'b0, op.we});
            check("mem_addr", daddr, op.addr);
            if (dWEN) begin
               check("mem_wdata", dstore, op.data);
               mem[daddr] = dstore;
               nwrites++;
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic access(input logic we, input word_t a, input word_t d, output int unsigned l);
      word_t exp;
      dmemREN   = !we;
      dmemWEN   = we;
      dmemaddr  = a;
      dmemstore = d;
      l = 0;
      #1;
      while (dhit !== 1'b1 && l < 100) begin
         step();
         l++;
      end
      check("dhit", {31'b0, dhit}, 32'd1);
      if (!we) begin
         exp = (rq.size() != 0) ? rq.pop_front() : 32'hBAD0BAD0;
         check("dmemload", dmemload, exp);
      end
      step();
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dhit"}, {31'b0, dhit}, 32'd0);
      check({tag, "_dREN"}, {31'b0, dREN}, 32'd0);
      check({tag, "_dWEN"}, {31'b0, dWEN}, 32'd0);
      check({tag, "_daddr"}, daddr, 32'd0);
      check({tag, "_dstore"}, dstore, 32'd0);
      check({tag, "_dmemload"}, dmemload, 32'd0);
      check({tag, "_flushed"}, {31'b0, flushed}, 32'd0);
   endtask

   initial begin
      RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
      dmemaddr = '0; dmemstore = '0; dwait = 1'b0; dload = '0;
      step();
      step();
      check_idle_outputs("reset");
      RST = 1'b0;
      step();

      // Cold read: two fills then hit, three cycles with a no-wait memory.
      expect_fill(32'h104);
      rq.push_back(memrd(32'h104));
      access(1'b0, 32'h104, '0, lat);
      check("cold_lat", lat, 32'd3);

      // Read hit on the other word of the block: no memory traffic.
      rq.push_back(memrd(32'h100));
      access(1'b0, 32'h100, '0, lat);
      check("hit_lat", lat, 32'd0);

      // Write hit then conflicting read forces write-back of the dirty block.
      access(1'b1, 32'h100, 32'hDEADBEEF, lat);
      check("whit_lat", lat, 32'd0);
      expect_wr(32'h100, 32'hDEADBEEF);
      expect_wr(32'h104, memrd(32'h104));
      expect_fill(32'h140);
      rq.push_back(memrd(32'h140));
      access(1'b0, 32'h140, '0, lat);
      check("wb_lat", lat, 32'd5);

      // Evicted data must come back from memory.
      expect_fill(32'h100);
      rq.push_back(32'hDEADBEEF);
      access(1'b0, 32'h100, '0, lat);
      check("refill_lat", lat, 32'd3);

      // dwait stall during LD0.
      expect_fill(32'h20C);
      rq.push_back(memrd(32'h20C));
      dmemREN = 1'b1; dmemaddr = 32'h20C;
      #1;
      check("stall_miss_dhit", {31'b0, dhit}, 32'd0);
      stall_cycles = 10;
      step();
      for (int i = 0; i < 10; i++) begin
         check("stall_daddr", daddr, 32'h208);
         check("stall_dREN", {31'b0, dREN}, 32'd1);
         check("stall_dhit", {31'b0, dhit}, 32'd0);
         step();
      end
      access(1'b0, 32'h20C, '0, lat);
      check("stall_tail_lat", lat, 32'd2);

      // Reset asserted in LD1 abandons the fill.
      mq.push_back('{1'b0, 32'h308, 32'h0});
      dmemREN = 1'b1; dmemaddr = 32'h30C;
      step();
      step();
      check("ld1_daddr", daddr, 32'h30C);
      check("ld1_dREN", {31'b0, dREN}, 32'd1);
      RST = 1'b1;
      dmemREN = 1'b0;
      #1;
      check_idle_outputs("midfill_rst");
      step();
      RST = 1'b0;
      step();
      expect_fill(32'h30C);
      rq.push_back(memrd(32'h30C));
      access(1'b0, 32'h30C, '0, lat);
      check("post_rst_lat", lat, 32'd3);

      // Dirty sets 0 and 5, clean valid set 1, then halt.
      expect_fill(32'h100);
      access(1'b1, 32'h100, 32'h11110000, lat);
      expect_fill(32'h16C);
      access(1'b1, 32'h16C, 32'h22225555, lat);
      expect_fill(32'h0C8);
      rq.push_back(memrd(32'h0C8));
      access(1'b0, 32'h0C8, '0, lat);
      expect_wr(32'h100, 32'h11110000);
      expect_wr(32'h104, memrd(32'h104));
      expect_wr(32'h168, memrd(32'h168));
      expect_wr(32'h16C, 32'h22225555);
      w0 = nwrites;
      halt = 1'b1;
      cyc = 0;
      #1;
      while (flushed !== 1'b1 && cyc < 100) begin
         step();
         cyc++;
      end
      check("flushed", {31'b0, flushed}, 32'd1);
      check("flush_cycles", cyc, 32'd13);
      check("flush_writes", nwrites - w0, 32'd4);

      // DONE is sticky and ignores requests.
      dmemREN = 1'b1; dmemaddr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         step();
         check("done_flushed", {31'b0, flushed}, 32'd1);
         check("done_dhit", {31'b0, dhit}, 32'd0);
         check("done_dREN", {31'b0, dREN}, 32'd0);
         check("done_dWEN", {31'b0, dWEN}, 32'd0);
      end
      check("memq_drained", mq.size(), 32'd0);
      check("readq_drained", rq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
